// File: rtl/fpu_serial_io_if.sv
// Byte-wide operand and result streams of the serial FPU wrapper.
// The master side drives operand bytes in and accepts result bytes out.
interface fpu_serial_io_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fpu_serial_io.sv
// Byte-serial operand loader and result unloader for a combinational FP adder:
// eight operand bytes in (MSB first), settle for RESULT_WAIT cycles, four sum bytes out.
module fpu_serial_io #(
    parameter int unsigned RESULT_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_serial_io_if.slave       bus,
    output logic [31:0]          op_a,
    output logic [31:0]          op_b,
    input  logic [31:0]          sum,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic [3:0]  wait_q,      wait_d;
    logic [63:0] stage_q,     stage_d;
    logic [31:0] op_a_q,      op_a_d;
    logic [31:0] op_b_q,      op_b_d;
    logic [31:0] result_q,    result_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q,  out_data_d;
    logic        busy_q,      busy_d;

    logic        in_hs;
    logic        out_hs;
    logic [1:0]  next_idx;
    logic [31:0] result_shifted;

    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = out_valid_q & bus.out_ready;

    // Selects the byte following the one currently on out_data, MSB first.
    assign next_idx       = cnt_q[1:0] + 2'd1;
    assign result_shifted = result_q << {next_idx, 3'b000};

    always_comb begin
        // NOTE: every *_d gets its hold value first so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        stage_d     = stage_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;

        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (in_hs) begin
                    stage_d = {stage_q[55:0], bus.in_data};
                    busy_d  = 1'b1;
                    if (cnt_q == 3'd7) begin
                        // Both operands reach the adder on the same edge, never partially.
                        op_a_d     = stage_d[63:32];
                        op_b_d     = stage_d[31:0];
                        cnt_d      = 3'd0;
                        wait_d     = 4'(RESULT_WAIT);
                        in_ready_d = 1'b0;
                        state_d    = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_WAIT: begin
                in_ready_d = 1'b0;
                if (wait_q == 4'd1) begin
                    result_d    = sum;
                    out_data_d  = sum[31:24];
                    out_valid_d = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = ST_SEND;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            ST_SEND: begin
                in_ready_d = 1'b0;
                if (out_hs) begin
                    if (cnt_q == 3'd3) begin
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                        cnt_d       = 3'd0;
                        state_d     = ST_LOAD;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        out_data_d = result_shifted[31:24];
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 3'd0;
            wait_q      <= 4'd0;
            stage_q     <= 64'd0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            result_q    <= 32'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            stage_q     <= stage_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fpu_serial_io.sv
// Bench for fpu_serial_io: two instances (RESULT_WAIT 1 and 3), each with a
// transaction-level model compared every cycle, plus hand-computed literal checks.
module tb_fpu_serial_io;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0] iv;
    logic [1:0] ordy;
    logic [7:0] idat [2];

    logic [1:0]  rdy;
    logic [1:0]  ov;
    logic [1:0]  bz;
    logic [7:0]  od [2];
    logic [31:0] oa [2];
    logic [31:0] ob [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int RW = (g == 0) ? 1 : 3;

        fpu_serial_io_if bus ();
        logic [31:0] op_a, op_b, sum;
        logic        busy;

        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idat[g];
        assign bus.out_ready = ordy[g];
        assign sum           = op_a ^ op_b;

        assign rdy[g] = bus.in_ready;
        assign ov[g]  = bus.out_valid;
        assign od[g]  = bus.out_data;
        assign oa[g]  = op_a;
        assign ob[g]  = op_b;
        assign bz[g]  = busy;

        fpu_serial_io #(.RESULT_WAIT(RW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus),
            .op_a  (op_a),
            .op_b  (op_b),
            .sum   (sum),
            .busy  (busy)
        );

        // Transaction model: collect 8 bytes, wait RW edges, emit 4 sum bytes.
        logic [7:0]  stage_bytes [$];
        logic [7:0]  res_bytes [$];
        int          wait_left;
        bit          fresh, m_ready, m_valid, m_busy;
        logic [31:0] m_a, m_b, m_s;
        logic [7:0]  m_data;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_bytes.delete();
                res_bytes.delete();
                wait_left = 0;
                fresh = 1'b1;
                m_ready = 1'b0;
                m_valid = 1'b0;
                m_busy = 1'b0;
                m_a = '0;
                m_b = '0;
                m_data = 8'h00;
            end else if (fresh) begin
                fresh = 1'b0;
                m_ready = 1'b1;
            end else if (m_ready) begin
                if (iv[g]) begin
                    stage_bytes.push_back(idat[g]);
                    m_busy = 1'b1;
                    if (stage_bytes.size() == 8) begin
                        m_a = {stage_bytes[0], stage_bytes[1], stage_bytes[2], stage_bytes[3]};
                        m_b = {stage_bytes[4], stage_bytes[5], stage_bytes[6], stage_bytes[7]};
                        stage_bytes.delete();
                        m_ready = 1'b0;
                        wait_left = RW;
                    end
                end
            end else if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) begin
                    m_s = m_a ^ m_b;
                    res_bytes = '{m_s[31:24], m_s[23:16], m_s[15:8], m_s[7:0]};
                    m_valid = 1'b1;
                    m_data = res_bytes[0];
                end
            end else if (m_valid && ordy[g]) begin
                void'(res_bytes.pop_front());
                if (res_bytes.size() == 0) begin
                    m_valid = 1'b0;
                    m_busy = 1'b0;
                    m_ready = 1'b1;
                end else begin
                    m_data = res_bytes[0];
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                check($sformatf("u%0d in_ready", g), 64'(rdy[g]), 64'(m_ready));
                check($sformatf("u%0d out_valid", g), 64'(ov[g]), 64'(m_valid));
                check($sformatf("u%0d busy", g), 64'(bz[g]), 64'(m_busy));
                check($sformatf("u%0d op_a", g), 64'(oa[g]), 64'(m_a));
                check($sformatf("u%0d op_b", g), 64'(ob[g]), 64'(m_b));
                if (m_valid) check($sformatf("u%0d out_data", g), 64'(od[g]), 64'(m_data));
            end
        end
    end

    // Drives one byte starting at a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input int k, input logic [7:0] b);
        int n = 0;
        iv[k] = 1'b1;
        idat[k] = b;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) expire("in_ready wait");
        @(negedge clk);
    endtask

    task automatic send_all(input int k, input logic [63:0] v, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                iv[k] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            send_byte(k, v[63 - 8*i -: 8]);
        end
        iv[k] = 1'b0;
    endtask

    task automatic wait_ov(input int k);
        int n = 0;
        while (!ov[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ov[k]) expire("out_valid rise");
    endtask

    task automatic drain(input int k);
        int n = 0;
        ordy[k] = 1'b1;
        while (ov[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ov[k]) expire("out_valid fall");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_bytes [4];
        iv = '0;
        ordy = '0;
        idat[0] = 8'h00;
        idat[1] = 8'h00;

        // Reset values and in_ready rising one edge after release
        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(rdy[0]), 64'd0);
        check("reset out_valid", 64'(ov[0]), 64'd0);
        check("reset out_data", 64'(od[0]), 64'd0);
        check("reset op_a", 64'(oa[0]), 64'd0);
        check("reset busy", 64'(bz[0]), 64'd0);
        rst_n = 1'b1;
        check("release in_ready low", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        check("release in_ready high", 64'(rdy[0]), 64'd1);

        // Basic transaction, RESULT_WAIT=1, back-to-back bytes, out_ready held high
        ordy[0] = 1'b1;
        send_all(0, 64'h3F800000_40000000, 1'b0);
        check("basic op_a", 64'(oa[0]), 64'h3F800000);
        check("basic op_b", 64'(ob[0]), 64'h40000000);
        check("basic out_valid at E0", 64'(ov[0]), 64'd0);
        exp_bytes = '{8'h7F, 8'h80, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("basic out_valid", 64'(ov[0]), 64'd1);
            check("basic byte", 64'(od[0]), 64'(exp_bytes[i]));
        end
        @(negedge clk);
        check("basic out_valid end", 64'(ov[0]), 64'd0);
        check("basic busy end", 64'(bz[0]), 64'd0);
        check("basic in_ready end", 64'(rdy[0]), 64'd1);

        // Input stalls with gaps, then spurious in_valid during WAIT and SEND
        ordy[0] = 1'b0;
        send_all(0, 64'h12345678_9ABCDEF0, 1'b1);
        iv[0] = 1'b1;
        idat[0] = 8'hAA;
        wait_ov(0);
        check("stall first byte", 64'(od[0]), 64'h88);
        repeat (2) @(negedge clk);
        check("stall held byte", 64'(od[0]), 64'h88);
        ordy[0] = 1'b1;
        repeat (3) @(negedge clk);
        iv[0] = 1'b0;
        drain(0);
        check("stall op_a", 64'(oa[0]), 64'h12345678);
        check("stall op_b", 64'(ob[0]), 64'h9ABCDEF0);

        // Reset after 5 operand bytes, then a clean load
        ordy[0] = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(0, (i == 0) ? 8'hC1 : ((i == 4) ? 8'h41 : 8'h00));
        iv[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset in_ready", 64'(rdy[0]), 64'd0);
        check("midreset busy", 64'(bz[0]), 64'd0);
        check("midreset op_a", 64'(oa[0]), 64'd0);
        check("midreset op_b", 64'(ob[0]), 64'd0);
        check("midreset out_valid", 64'(ov[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset in_ready back", 64'(rdy[0]), 64'd1);
        send_all(0, 64'hC1000000_41200000, 1'b0);
        check("fresh op_a", 64'(oa[0]), 64'hC1000000);
        check("fresh op_b", 64'(ob[0]), 64'h41200000);
        wait_ov(0);
        check("fresh first byte", 64'(od[0]), 64'h80);
        drain(0);

        // Output backpressure with RESULT_WAIT=3
        ordy[1] = 1'b0;
        send_all(1, 64'h3F800000_40000000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("rw3 out_valid early", 64'(ov[1]), 64'd0);
            @(negedge clk);
        end
        check("rw3 out_valid early", 64'(ov[1]), 64'd0);
        @(negedge clk);
        check("rw3 out_valid at E0+3", 64'(ov[1]), 64'd1);
        check("rw3 first byte", 64'(od[1]), 64'h7F);
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid held", 64'(ov[1]), 64'd1);
            check("bp out_data held", 64'(od[1]), 64'h80);
            @(negedge clk);
        end
        drain(1);
        check("bp busy end", 64'(bz[1]), 64'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
